servo_pwm_controller: RTL and testbench
=======================================

// Module: servo_pwm_controller
// PURPOSE
//  Single-channel hobby-servo PWM generator. Converts an 8-bit position code into a
//  50 Hz frame whose high pulse spans 1.0 ms..~2.0 ms. Instantiated once by the
//  servo channel selector, which demuxes servo_pwm onto one of N servo outputs.
// PARAMETERS
//  in_freq   50  Main_clock frequency in MHz (integer).
//  out_freq  50  internal tick rate in MHz; must divide in_freq exactly;
//                equal to in_freq => tick enable tied high (no division).
// PORTS
//  Main_clock  in   1  system clock, single clock domain, rising edge.
//  reset       in   1  asynchronous, active-low reset.
//  duty_cycle  in   8  position code: 0 = 1.0 ms, 255 = ~2.0 ms pulse.
//  servo_pwm   out  1  PWM output, registered, active-high pulse.
// BEHAVIOUR
//  - Reset (reset=0, async): tick divider, frame counter and shadow cleared to 0;
//    servo_pwm=0. First frame starts on first tick after reset deasserts.
//  - Tick: divider counts 0..DIV-1, DIV=in_freq/out_freq; tick=1 for one
//    Main_clock cycle when divider==DIV-1. DIV==1 => tick every cycle.
//  - Frame: FRAME=20000*out_freq ticks (20 ms). Frame counter advances on tick,
//    wraps FRAME-1 -> 0. Width $clog2(FRAME)+1 bits.
//  - Pulse: HIGH=1000*out_freq + ((shadow*1000*out_freq)>>8) ticks; compute in
//    32-bit unsigned, truncation toward zero. servo_pwm=1 while frame count < HIGH,
//    else 0; output registered => 1 Main_clock latency vs counter.
//  - duty_cycle sampled into shadow on the tick where frame counter wraps to 0
//    (and on first tick after reset); mid-frame changes affect next frame only.
//  - duty=0 => 1000*out_freq ticks; duty=255 => 1000*out_freq+996*out_freq
//    (approx, per truncation). HIGH always < FRAME; no 0% or 100% cases exist.
//  - reset asserted mid-pulse => servo_pwm drops to 0 immediately (async).
// CONFIGURATION
//  SERVO_SHADOW_EN defined: duty_cycle captured once per frame (as above).
//  SERVO_SHADOW_EN undefined: HIGH recomputed every cycle from live duty_cycle;
//   a mid-frame change may shorten/extend the current pulse (runt allowed).
// STRUCTURE
//  Package servo_pkg: FRAME_US=20000, MIN_PULSE_US=1000, SPAN_US=1000,
//   DUTY_W=8 constants; shared with the channel selector.
//  Sub-module servo_tick_gen (params in_freq,out_freq; out tick) = clock-enable
//   divider. Top holds frame counter, shadow register, pulse-width math, output reg.
// TESTING  (bench uses in_freq=50, out_freq=1 => DIV=50, FRAME=20000 ticks)
//  1. reset=0 for 10 cycles -> servo_pwm=0, counters 0; release -> pwm rises
//     within 2 Main_clock cycles of first tick.
//  2. duty=0 -> high 1000 ticks (50000 clk), period 20000 ticks (1,000,000 clk).
//  3. duty=128 -> high 1500 ticks; duty=255 -> high 1996 ticks; period unchanged.
//  4. change duty 0->255 at tick 500 of a frame -> that pulse stays 1000 ticks,
//     next frame 1996 ticks (SERVO_SHADOW_EN); without macro pulse ends at 1996.
//  5. assert reset at tick 700 of pulse -> servo_pwm=0 same cycle; after release
//     full new frame with correct width.
//  6. in_freq=out_freq=50, duty=128 -> tick every clk, high 75000 clk, period 1e6.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo timing constants and pulse-width helper for the PWM controller and channel selector.
package servo_pkg;

  localparam int unsigned FRAME_US     = 32'd20000;
  localparam int unsigned MIN_PULSE_US = 32'd1000;
  localparam int unsigned SPAN_US      = 32'd1000;
  localparam int unsigned DUTY_W       = 32'd8;

  // High time in ticks: fixed minimum plus duty-scaled span, truncated toward zero.
  function automatic logic [31:0] pulse_ticks(input logic [DUTY_W-1:0] duty,
                                              input int unsigned freq);
    logic [31:0] span;
    span = (32'(duty) * SPAN_US * freq) >> 8'd8;
    return (MIN_PULSE_US * freq) + span;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Clock-enable divider: pulses tick for one Main_clock cycle every in_freq/out_freq cycles.
module servo_tick_gen #(
  parameter int unsigned in_freq  = 50,
  parameter int unsigned out_freq = 50
) (
  input  logic Main_clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV   = in_freq / out_freq;
  localparam int          DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_r;
  logic             at_end_s;

  // With DIV==1 the divider is pinned at zero, so tick is constantly high.
  assign at_end_s = (div_r == DIV_W'(DIV - 32'd1));
  assign tick     = at_end_s;

  // Divider counts 0..DIV-1 and wraps.
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      div_r <= '0;
    end else if (at_end_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/servo_pwm_controller.sv
// Single-channel 50 Hz hobby-servo PWM generator (1.0..~2.0 ms pulse from an 8-bit code).
// Define SERVO_SHADOW_EN to latch duty_cycle once per frame; otherwise the live code is used.
module servo_pwm_controller
  import servo_pkg::*;
#(
  parameter int unsigned in_freq  = 50,
  parameter int unsigned out_freq = 50
) (
  input  logic              Main_clock,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty_cycle,
  output logic              servo_pwm
);

  localparam int unsigned FRAME = FRAME_US * out_freq;
  localparam int          CNT_W = $clog2(FRAME) + 1;

  logic             tick_s;
  logic             running_r;
  logic             wrap_s;
  logic             start_s;
  logic [CNT_W-1:0] frame_cnt_r;
  logic [31:0]      high_s;

  servo_tick_gen #(
    .in_freq  (in_freq),
    .out_freq (out_freq)
  ) u_tick (
    .Main_clock (Main_clock),
    .reset      (reset),
    .tick       (tick_s)
  );

  // A frame begins on the first tick after reset and on every counter wrap.
  assign wrap_s  = (frame_cnt_r == CNT_W'(FRAME - 32'd1));
  assign start_s = tick_s && (!running_r || wrap_s);

  // Frame counter advances one step per tick; the frame-start tick leaves it at zero.
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      running_r   <= 1'b0;
      frame_cnt_r <= '0;
    end else if (tick_s) begin
      running_r <= 1'b1;
      if (start_s) begin
        frame_cnt_r <= '0;
      end else begin
        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      end
    end
  end

`ifdef SERVO_SHADOW_EN
  logic [DUTY_W-1:0] shadow_r;

  // Position code is frozen for the whole frame so pulses are never runts.
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      shadow_r <= '0;
    end else if (start_s) begin
      shadow_r <= duty_cycle;
    end
  end

  assign high_s = pulse_ticks(shadow_r, out_freq);
`else
  assign high_s = pulse_ticks(duty_cycle, out_freq);
`endif

  // Registered output; held low until the first frame has actually started.
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      servo_pwm <= 1'b0;
    end else begin
      servo_pwm <= running_r && (32'(frame_cnt_r) < high_s);
    end
  end

endmodule

// File: tb/tb_servo_pwm_controller.sv
// Directed bench: a DIV=1 instance for widths/periods/duty changes, a DIV=2 instance for reset cases.
module tb_servo_pwm_controller;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic [7:0] duty1, duty2;
  logic       pwm1, pwm2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  int rises1[$];
  int widths1[$];
  int rises2[$];
  int widths2[$];
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  int   last1 = 0;
  int   last2 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  servo_pwm_controller #(.in_freq(1), .out_freq(1)) u_dut1 (
    .Main_clock (clk),
    .reset      (rst1),
    .duty_cycle (duty1),
    .servo_pwm  (pwm1)
  );

  servo_pwm_controller #(.in_freq(2), .out_freq(1)) u_dut2 (
    .Main_clock (clk),
    .reset      (rst2),
    .duty_cycle (duty2),
    .servo_pwm  (pwm2)
  );

  // Edge recorder: rise cycle and high width (in clocks) for each instance.
  always @(negedge clk) begin
    if (pwm1 && !prev1) begin
      rises1.push_back(cyc);
      last1 <= cyc;
    end
    if (!pwm1 && prev1) widths1.push_back(cyc - last1);
    if (pwm2 && !prev2) begin
      rises2.push_back(cyc);
      last2 <= cyc;
    end
    if (!pwm2 && prev2) widths2.push_back(cyc - last2);
    prev1 <= pwm1;
    prev2 <= pwm2;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_rises(input int which, input int need, input int limit, input string tag);
    int k = 0;
    while ((((which == 1) ? rises1.size() : rises2.size()) < need) && (k < limit)) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, int'(((which == 1) ? rises1.size() : rises2.size()) >= need), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w4;
    int exp_w1[5];
    rst1  = 1'b0;
    rst2  = 1'b0;
    duty1 = 8'd0;
    duty2 = 8'd128;
`ifdef SERVO_SHADOW_EN
    w4 = 1000;
`else
    w4 = 1996;
`endif
    exp_w1 = '{1000, 1500, 1996, w4, 1996};

    fork
      begin : dut1_seq
        int rel1;
        int r;
        repeat (10) @(negedge clk);
        check_eq("rst_pwm1", int'(pwm1), 0);
        rel1 = cyc;
        rst1 = 1'b1;
        wait_rises(1, 1, 50, "rise1_seen");
        r = (rises1.size() > 0) ? rises1[0] : rel1;
        check_eq("lat1", r - rel1, 2);
        goto_cyc(r + 5000);
        duty1 = 8'd128;
        goto_cyc(r + 25000);
        duty1 = 8'd255;
        goto_cyc(r + 45000);
        duty1 = 8'd0;
        goto_cyc(r + 60500);
        duty1 = 8'd255;
        goto_cyc(r + 82500);
        check_eq("rise1_count", rises1.size(), 5);
        for (int i = 0; i < 5; i++) begin
          check_eq($sformatf("width1[%0d]", i),
                   (i < widths1.size()) ? widths1[i] : -1, exp_w1[i]);
        end
        for (int i = 0; i < 4; i++) begin
          check_eq($sformatf("period1[%0d]", i),
                   (i + 1 < rises1.size()) ? (rises1[i + 1] - rises1[i]) : -1, 20000);
        end
      end
      begin : dut2_seq
        int rel2;
        int r2;
        repeat (10) @(negedge clk);
        check_eq("rst_pwm2", int'(pwm2), 0);
        rel2 = cyc;
        rst2 = 1'b1;
        wait_rises(2, 1, 50, "rise2_seen");
        r2 = (rises2.size() > 0) ? rises2[0] : rel2;
        check_eq("lat2", r2 - rel2, 3);
        goto_cyc(r2 + 1400);
        check_eq("mid_pulse2", int'(pwm2), 1);
        @(posedge clk);
        #2 rst2 = 1'b0;
        #1 check_eq("rst_async2", int'(pwm2), 0);
        repeat (5) @(negedge clk);
        check_eq("rst_hold2", int'(pwm2), 0);
        rel2 = cyc;
        rst2 = 1'b1;
        wait_rises(2, 2, 50, "rise2b_seen");
        r2 = (rises2.size() > 1) ? rises2[1] : rel2;
        check_eq("lat2b", r2 - rel2, 3);
        goto_cyc(r2 + 3100);
        check_eq("width2_count", widths2.size(), 2);
        check_eq("width2b", (widths2.size() > 1) ? widths2[1] : -1, 3000);
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
